// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the ID-stage hazard/stall controller.
// Holds the stall_cause codes and the controller FSM state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_LU     = 2'd1,
    CAUSE_BR_ALU = 2'd2,
    CAUSE_BR_LD  = 2'd3
  } cause_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: purely combinational hazard detector.
// Produces the number of bubbles required by the instruction in ID and the
// matching stall cause. A branch weighs its EX and MEM producers and takes
// the largest requirement; on equal bubble counts the higher cause code wins.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int RA_W          = 5,
  parameter int CNT_W         = 2,
  parameter int LU_BUB        = 1,
  parameter int BR_ALU_BUB    = 1,
  parameter int BR_LD_EX_BUB  = 2,
  parameter int BR_LD_MEM_BUB = 1
) (
  input  logic [RA_W-1:0]  i_id_rs,
  input  logic [RA_W-1:0]  i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_branch,
  input  logic             i_ex_regWr,
  input  logic             i_ex_memtoreg,
  input  logic [RA_W-1:0]  i_ex_rw,
  input  logic             i_mem_regWr,
  input  logic             i_mem_memtoreg,
  input  logic [RA_W-1:0]  i_mem_rw,
  output logic [CNT_W-1:0] o_n,
  output logic [1:0]       o_cause
);

  logic             w_rs_v;
  logic             w_rt_v;
  logic             w_ex_hit;
  logic             w_mem_hit;
  logic [CNT_W-1:0] w_ex_n;
  logic [1:0]       w_ex_c;
  logic [CNT_W-1:0] w_mem_n;
  logic [1:0]       w_mem_c;

  // $0 is never a real dependency, and an unread field must not stall.
  assign w_rs_v    = i_id_use_rs && (i_id_rs != '0);
  assign w_rt_v    = i_id_use_rt && (i_id_rt != '0);
  assign w_ex_hit  = i_ex_regWr  && ((w_rs_v && (i_ex_rw  == i_id_rs)) || (w_rt_v && (i_ex_rw  == i_id_rt)));
  assign w_mem_hit = i_mem_regWr && ((w_rs_v && (i_mem_rw == i_id_rs)) || (w_rt_v && (i_mem_rw == i_id_rt)));

  // Branch candidates: EX producer (load or ALU) and MEM load producer.
  always_comb begin
    w_ex_n  = '0;
    w_ex_c  = CAUSE_NONE;
    w_mem_n = '0;
    w_mem_c = CAUSE_NONE;
    if (w_ex_hit && i_ex_memtoreg) begin
      w_ex_n = CNT_W'(BR_LD_EX_BUB);
      w_ex_c = CAUSE_BR_LD;
    end else if (w_ex_hit) begin
      w_ex_n = CNT_W'(BR_ALU_BUB);
      w_ex_c = CAUSE_BR_ALU;
    end else begin
      w_ex_n = '0;
    end
    if (w_mem_hit && i_mem_memtoreg) begin
      w_mem_n = CNT_W'(BR_LD_MEM_BUB);
      w_mem_c = CAUSE_BR_LD;
    end else begin
      w_mem_n = '0;
    end
  end

  // Select the final requirement for the ID instruction.
  always_comb begin
    o_n     = '0;
    o_cause = CAUSE_NONE;
    if (i_id_branch) begin
      if ((w_mem_n > w_ex_n) || ((w_mem_n == w_ex_n) && (w_mem_c > w_ex_c))) begin
        o_n     = w_mem_n;
        o_cause = w_mem_c;
      end else begin
        o_n     = w_ex_n;
        o_cause = w_ex_c;
      end
    end else if (w_ex_hit && i_ex_memtoreg) begin
      o_n     = CNT_W'(LU_BUB);
      o_cause = CAUSE_LU;
    end else begin
      o_n     = '0;
      o_cause = CAUSE_NONE;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard and stall controller for the 5-stage
// pipeline. The first bubble is issued in the detection cycle; requirements
// of two or more bubbles continue in a counted STALL state. A data-memory
// wait freezes everything; a flush cancels any stall in progress.
// Optional build macro: HAZARD_PERF_EN adds saturating bubble/freeze counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W          = 5,
  parameter int CNT_W         = 2,
  parameter int LU_BUB        = 1,
  parameter int BR_ALU_BUB    = 1,
  parameter int BR_LD_EX_BUB  = 2,
  parameter int BR_LD_MEM_BUB = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_branch,
  input  logic            ex_regWr,
  input  logic            ex_memtoreg,
  input  logic [RA_W-1:0] ex_rw,
  input  logic            mem_regWr,
  input  logic            mem_memtoreg,
  input  logic [RA_W-1:0] mem_rw,
  input  logic            mem_ready,
  input  logic            flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_freeze_cnt,
`endif
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            idex_bubble,
  output logic            pipe_freeze,
  output logic            stall_busy,
  output logic [1:0]      stall_cause
);

  localparam int MAX_BUB = (1 << CNT_W) - 1;

  // Bubble counts that cannot be represented by the counter are rejected.
  if ((LU_BUB > MAX_BUB) || (BR_ALU_BUB > MAX_BUB) ||
      (BR_LD_EX_BUB > MAX_BUB) || (BR_LD_MEM_BUB > MAX_BUB)) begin : g_bub_range
    $error("hazard_stall_ctrl: a *_BUB parameter exceeds 2^CNT_W-1");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [1:0]       r_cause;
  logic [1:0]       w_next_cause;
  logic [CNT_W-1:0] w_n;
  logic [1:0]       w_match_cause;
  logic             w_hold;
  logic             w_bubble;
  logic             w_freeze;
  logic             w_busy;
  logic [1:0]       w_cause_out;

  hazard_match #(
    .RA_W(RA_W), .CNT_W(CNT_W), .LU_BUB(LU_BUB), .BR_ALU_BUB(BR_ALU_BUB),
    .BR_LD_EX_BUB(BR_LD_EX_BUB), .BR_LD_MEM_BUB(BR_LD_MEM_BUB)
  ) u_match (
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_branch(id_branch), .i_ex_regWr(ex_regWr), .i_ex_memtoreg(ex_memtoreg),
    .i_ex_rw(ex_rw), .i_mem_regWr(mem_regWr), .i_mem_memtoreg(mem_memtoreg),
    .i_mem_rw(mem_rw), .o_n(w_n), .o_cause(w_match_cause)
  );

  // State, remaining-bubble counter and cause register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_cause <= w_next_cause;
    end
  end

  // Next state and outputs: reset, then freeze, then flush, then stall logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_cause = r_cause;
    w_hold       = 1'b0;
    w_bubble     = 1'b0;
    w_freeze     = 1'b0;
    w_busy       = 1'b0;
    w_cause_out  = CAUSE_NONE;
    if (!rst_n) begin
      w_next_state = ST_IDLE;
      w_next_cnt   = '0;
      w_next_cause = CAUSE_NONE;
    end else if (!mem_ready) begin
      // Frozen: hold PC and IF/ID, no bubble, no new detection.
      w_freeze = 1'b1;
      w_hold   = 1'b1;
      w_busy   = (r_state == ST_STALL);
      if (r_state == ST_STALL) begin
        w_cause_out = r_cause;
      end else begin
        w_cause_out = CAUSE_NONE;
      end
      if (flush) begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
        w_next_cause = CAUSE_NONE;
      end else begin
        w_next_state = r_state;
      end
    end else if (flush) begin
      // Redirect wins: release the holds so the new PC is taken.
      w_busy       = (r_state == ST_STALL);
      w_next_state = ST_IDLE;
      w_next_cnt   = '0;
      w_next_cause = CAUSE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_n != '0) begin
            w_hold      = 1'b1;
            w_bubble    = 1'b1;
            w_cause_out = w_match_cause;
            if (w_n > CNT_W'(1)) begin
              w_next_state = ST_STALL;
              w_next_cnt   = w_n - CNT_W'(1);
              w_next_cause = w_match_cause;
            end else begin
              w_next_state = ST_IDLE;
            end
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_STALL: begin
          w_hold      = 1'b1;
          w_bubble    = 1'b1;
          w_busy      = 1'b1;
          w_cause_out = r_cause;
          if (r_cnt <= CNT_W'(1)) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
            w_next_cause = CAUSE_NONE;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
          w_next_cause = CAUSE_NONE;
        end
      endcase
    end
  end

  assign pc_hold     = w_hold;
  assign ifid_hold   = w_hold;
  assign idex_bubble = w_bubble;
  assign pipe_freeze = w_freeze;
  assign stall_busy  = w_busy;
  assign stall_cause = w_cause_out;

`ifdef HAZARD_PERF_EN
  // Saturating event counters for bubbles and freeze cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= 32'd0;
      perf_freeze_cnt <= 32'd0;
    end else begin
      if (w_bubble && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end else begin
        perf_bubble_cnt <= perf_bubble_cnt;
      end
      if (w_freeze && (perf_freeze_cnt != 32'hFFFF_FFFF)) begin
        perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
      end else begin
        perf_freeze_cnt <= perf_freeze_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised ID-stage hazard and stall controller for the 5-stage MIPS pipeline.
- Supersedes the single-cycle branch bubble logic with these additions:
  - load-use detection;
  - multi-bubble branch stalls with counted sequencing;
  - whole-pipeline freeze on data-memory wait;
  - flush cancel.
- Drives the PC, IF/ID and ID/EX pipeline register controls.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 2, stall counter width.
- LU_BUB, 1, bubbles for ordinary load-use (load in EX).
- BR_ALU_BUB, 1, bubbles for branch depending on ALU result in EX.
- BR_LD_EX_BUB, 2, bubbles for branch depending on load in EX.
- BR_LD_MEM_BUB, 1, bubbles for branch depending on load in MEM.
- Constraint: every *_BUB value ≤ 2^CNT_W-1. Values above that limit are an elaboration error.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  RA_W  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt.
- id_branch  in  1  ID holds any compare-in-ID branch (beq, bne, bgez, bgtz, blez, bltz).
- ex_regWr, ex_memtoreg  in  1  write-back controls of the instruction in EX.
- ex_rw  in  RA_W  destination register of the instruction in EX.
- mem_regWr, mem_memtoreg  in  1  write-back controls of the instruction in MEM.
- mem_rw  in  RA_W  destination register of the instruction in MEM.
- mem_ready  in  1  data memory completed the access this cycle.
- flush  in  1  redirect from jump/exception; kills IF/ID contents.
- pc_hold  out  1  inhibit PC update.
- ifid_hold  out  1  inhibit IF/ID load.
- idex_bubble  out  1  load a NOP into ID/EX.
- pipe_freeze  out  1  hold EX/MEM and MEM/WB.
- stall_busy  out  1  FSM is in STALL.
- stall_cause  out  2  0 none, 1 load-use, 2 branch-ALU, 3 branch-load.

Behaviour:
- Reset:
  - State IDLE, cnt=0, cause register=0.
  - All outputs 0 while rst_n=0.
- Match rules:
  - A source is matched only when its use bit is set and the address is nonzero.
  - EX match: ex_regWr=1 and ex_rw equals a matched source.
  - MEM match: mem_regWr=1 and mem_rw equals a matched source.
- Requirement N and cause (combinational, evaluated in IDLE only):
  - Non-branch ID instruction:
    - EX match with ex_memtoreg=1 → N=LU_BUB, cause 1.
    - Otherwise N=0.
  - id_branch=1, evaluate all three candidates:
    - EX match with ex_memtoreg=1 → BR_LD_EX_BUB, cause 3.
    - EX match with ex_memtoreg=0 → BR_ALU_BUB, cause 2.
    - MEM match with mem_memtoreg=1 → BR_LD_MEM_BUB, cause 3.
    - N is the maximum of the matching candidates. On a tie, the higher cause code wins.
- Freeze (mem_ready=0), highest priority:
  - pipe_freeze=1, pc_hold=1, ifid_hold=1, idex_bubble=0.
  - FSM and cnt hold their values. No new detection.
  - stall_cause shows the held cause.
- Flush (flush=1 with mem_ready=1):
  - Next state IDLE, cnt=0.
  - Same-cycle pc_hold, ifid_hold and idex_bubble are 0, so the redirect wins.
  - stall_cause=0.
- Flush during freeze: applied at the same edge as in the non-frozen case (IDLE, cnt=0). Freeze outputs still drive that cycle.
- IDLE with N≥1:
  - Same cycle: pc_hold=ifid_hold=idex_bubble=1, stall_cause=cause.
  - If N≥2: next state STALL, cnt=N-1, cause registered.
  - If N=1: remain in IDLE.
  - No latency: the first bubble is in the detection cycle.
- STALL:
  - Outputs asserted with the registered cause; stall_busy=1.
  - Each non-frozen cycle decrements cnt.
  - When cnt==1 the next state is IDLE.
  - No re-detection while in STALL.
- Total bubbles inserted for one hazard is exactly N; freeze cycles are not counted.
- pipe_freeze equals ~mem_ready, gated to 0 during reset.
- A reset asserted mid-stall returns the block to IDLE immediately. No pending bubble survives reset.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_bubble_cnt[31:0] and perf_freeze_cnt[31:0].
  - perf_bubble_cnt increments on every cycle with idex_bubble=1.
  - perf_freeze_cnt increments on every cycle with pipe_freeze=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent. Core behaviour is identical in both builds.

Decomposition:
- Package hazard_pkg holds:
  - the stall_cause encodings (CAUSE_NONE, CAUSE_LU, CAUSE_BR_ALU, CAUSE_BR_LD);
  - the FSM state encoding (ST_IDLE, ST_STALL).
- Sub-module hazard_match (purely combinational) computes N and cause from the ID/EX/MEM fields.
- hazard_stall_ctrl holds the FSM, counter, freeze/flush priority and perf counters.

Test Plan:
- Load-use:
  - Stimulus: EX lw to $8 (ex_regWr=1, ex_memtoreg=1, ex_rw=8); ID add reading rs=8; mem_ready=1.
  - Required: exactly 1 cycle of idex_bubble/pc_hold/ifid_hold, cause 1, stall_busy stays 0.
- Branch on EX load:
  - Stimulus: EX lw to $9; ID beq rs=9.
  - Required: 2 consecutive bubble cycles, stall_busy=1 in cycle 2, cause 3 both cycles, then IDLE.
- Register zero and unused source:
  - Stimulus (a): EX lw to $0 with ID beq rs=0.
  - Stimulus (b): ID use_rt=0 with rt matching ex_rw=5.
  - Required: no stall in either case.
- Freeze mid-stall:
  - Stimulus: branch-load stall starts; mem_ready=0 for 3 cycles during cycle 2.
  - Required: pipe_freeze=1 and idex_bubble=0 for those 3 cycles; cnt held; one remaining bubble after mem_ready=1; total bubbles = 2.
- Flush cancels:
  - Stimulus: flush=1 in STALL cycle 2 of a 2-bubble stall.
  - Required: no bubble that cycle, state IDLE next cycle, stall_cause=0.
- Async reset:
  - Stimulus: drop rst_n mid-STALL between edges.
  - Required: all outputs 0 immediately; IDLE after release; with HAZARD_PERF_EN both perf counters read 0.
